// File: rtl/systolic_data_setup_if.sv
// Row handshake into the systolic feeder and the skewed stream out to the MMU.
// The feeder takes the slave side; whoever supplies rows and consumes the diagonal takes master.
interface systolic_data_setup_if #(
  parameter int unsigned MATRIX_WIDTH = 4
) ();
  logic                         in_valid;
  logic                         in_ready;
  logic [MATRIX_WIDTH-1:0][7:0] in_data;
  logic                         in_signed;
  logic                         in_last;
  logic [MATRIX_WIDTH-1:0][7:0] systolic_data;
  logic                         systolic_signed;

  modport master (
    output in_valid, in_data, in_signed, in_last,
    input  in_ready, systolic_data, systolic_signed
  );

  modport slave (
    input  in_valid, in_data, in_signed, in_last,
    output in_ready, systolic_data, systolic_signed
  );
endinterface

// File: rtl/systolic_data_setup.sv
// Diagonal skew feeder for the systolic MMU: lane k trails lane 0 by k cycles, plus sign framing.
// Optional per-batch row counter output when SYSTOLIC_SETUP_ROW_COUNT_EN is defined.
module systolic_data_setup #(
  parameter int unsigned MATRIX_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  systolic_data_setup_if.slave bus,
  output logic                 busy,
  output logic                 done
`ifdef SYSTOLIC_SETUP_ROW_COUNT_EN
  ,
  output logic [15:0]          row_count
`endif
);

  localparam int unsigned CntW = $clog2(MATRIX_WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StStream, StDrain} state_e;

  state_e                       state_q, state_d;
  logic [CntW-1:0]              drain_q, drain_d;
  logic                         done_q, done_d;
  logic                         run_q;
  logic                         batch_sign_q;
  logic [MATRIX_WIDTH-1:0]      first_q;
  logic                         in_ready;
  logic                         accept;
  logic                         first_accept;
  logic [MATRIX_WIDTH-1:0][7:0] lane_out;

  // run_q keeps in_ready low while reset is held and until the first edge after release.
  assign in_ready     = enable & run_q & (state_q != StDrain);
  assign accept       = bus.in_valid & in_ready;
  assign first_accept = accept & (state_q == StIdle);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (bus.in_last) begin
            state_d = StDrain;
            drain_d = CntW'(MATRIX_WIDTH);
          end else begin
            state_d = StStream;
          end
        end
      end
      StStream: begin
        if (accept && bus.in_last) begin
          state_d = StDrain;
          drain_d = CntW'(MATRIX_WIDTH);
        end
      end
      StDrain: begin
        drain_d = drain_q - 1'b1;
        if (drain_q == CntW'(1)) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      drain_q <= '0;
      done_q  <= 1'b0;
    end else if (enable) begin
      state_q <= state_d;
      drain_q <= drain_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // first_q marks the diagonal of the batch's first row; the sign is shown while it crosses lanes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      batch_sign_q <= 1'b0;
      first_q      <= '0;
    end else if (enable) begin
      if (first_accept) begin
        batch_sign_q <= bus.in_signed;
      end
      first_q[0] <= first_accept;
      for (int i = 1; i < int'(MATRIX_WIDTH); i++) begin
        first_q[i] <= first_q[i-1];
      end
    end
  end

  for (genvar k = 0; k < int'(MATRIX_WIDTH); k++) begin : g_lane
    logic [k:0][7:0] sr_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sr_q <= '0;
      end else if (enable) begin
        sr_q[0] <= accept ? bus.in_data[k] : 8'h00;
        for (int i = 1; i <= k; i++) begin
          sr_q[i] <= sr_q[i-1];
        end
      end
    end

    assign lane_out[k] = sr_q[k];
  end

`ifdef SYSTOLIC_SETUP_ROW_COUNT_EN
  logic [15:0] row_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_cnt_q <= '0;
    end else if (first_accept) begin
      row_cnt_q <= 16'd1;
    end else if (accept && (row_cnt_q != 16'hFFFF)) begin
      row_cnt_q <= row_cnt_q + 16'd1;
    end
  end

  assign row_count = row_cnt_q;
`endif

  assign bus.in_ready        = in_ready;
  assign bus.systolic_data   = lane_out;
  assign bus.systolic_signed = batch_sign_q & (|first_q);
  assign busy                = (state_q != StIdle);
  assign done                = done_q;

endmodule

// File: doc/systolic_data_setup.md
Name: systolic_data_setup

Overview:
- Feeder at the input end of matrix_multiply_unit.
- Accepts one activation row (MATRIX_WIDTH bytes) per cycle over a valid/ready handshake.
- Emits the row diagonally skewed on systolic_data: lane k is delayed k cycles relative to lane 0. It also generates the systolic_signed framing the MMU expects.
- Replaces the hand-written per-lane skew processes the MMU bench uses today.

Parameters:
- MATRIX_WIDTH, 4, number of lanes; also the skew depth (lane k delay = k).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-low.
- enable  in  1  global advance. When 0, all state and pipeline registers hold and in_ready=0.
- in_valid  in  1  row offered.
- in_ready  out  1  row accepted when in_valid and in_ready are both 1.
- in_data  in  MATRIX_WIDTH x byte_type  row; element k goes to lane k.
- in_signed  in  1  batch signedness; sampled only on the first accepted row of a batch.
- in_last  in  1  marks the final row of a batch.
- systolic_data  out  MATRIX_WIDTH x byte_type  skewed data to the MMU.
- systolic_signed  out  1  sign framing to the MMU.
- busy  out  1  high in STREAM or DRAIN.
- done  out  1  one-cycle pulse after the batch's last lane-(MATRIX_WIDTH-1) byte has been emitted.

Behaviour:
- Reset (rst=0, async): all outputs and registers are 0, state=IDLE; in_ready rises on the first cycle after reset release if enable=1.
- Reset mid-batch discards all in-flight rows immediately; no done pulse.
- Skew, on each enabled cycle:
  - lane 0 register <= accepted in_data[0], or 0 if no row was accepted that cycle (bubble).
  - lane k (k>0) is a k+1-deep shift chain of byte registers fed with in_data[k] or 0.
  - Latency: a row accepted at edge t appears on lane k at the output after edge t+1+k.
  - For MATRIX_WIDTH=4, one row occupies 4 consecutive lane-diagonal cycles.
- Bubbles: in_valid=0 during STREAM injects a zero row. A zero row is legal and contributes 0 to MMU sums.
- State machine:
  - IDLE: in_ready=enable. An accepted row latches batch_sign=in_signed. Next state is STREAM, or DRAIN if in_last=1 on that row.
  - STREAM: in_ready=enable. Accepting a row with in_last=1 goes to DRAIN and loads drain_cnt=MATRIX_WIDTH.
  - DRAIN: in_ready=0. drain_cnt decrements on each enabled cycle. When it reaches 0, done=1 for one cycle and the next state is IDLE.
  - DRAIN exists so a following batch with a different sign never shares the diagonal with the previous batch.
- systolic_signed = batch_sign from the cycle the batch's first lane-0 byte is output through the cycle its first lane-(MATRIX_WIDTH-1) byte is output, inclusive (MATRIX_WIDTH cycles); otherwise 0.
- enable=0 freezes the shift chains, drain_cnt, state, done and systolic_signed. Outputs hold their values; nothing is accepted.
- Simultaneous in_valid and enable falling: no accept, because in_ready is 0 combinationally.
- Width: data is passed through bit-exact. No sign extension is done here; signedness is conveyed only via systolic_signed.

Optional Feature:
- SYSTOLIC_SETUP_ROW_COUNT_EN defined:
  - adds output row_count (16 bits), the number of rows accepted in the current batch, including the first;
  - cleared on the first accept of a new batch;
  - saturates at 16'hFFFF;
  - holds its value after done until the next batch starts.
- Macro undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Unsigned batch:
  - stimulus: rows {40,76,19,192},{3,84,12,8},{54,18,255,120},{30,84,122,2} on consecutive cycles, in_signed=0, in_last on row 4;
  - response: lane0 outputs 40,3,54,30 starting after edge t+1; lane3 outputs 192,8,120,2 starting 3 cycles later; systolic_signed stays 0; done 1 cycle after lane3's value 2 leaves.
- Signed batch fed into matrix_multiply_unit, with weights {-13,89,92,9},{-84,104,86,18},{-128,73,14,3},{-98,127,78,29} loaded:
  - stimulus: rows {74,91,64,10},{5,28,26,9},{56,9,72,127},{94,26,92,8}, in_signed=1;
  - response: systolic_signed high for exactly 4 cycles aligned as specified; MMU results {-17778,21992,16310,2786},{-6627,6398,3934,888},{-23146,27305,16840,4565},{-15966,18802,12796,1822}.
- Bubble and stall:
  - stimulus: in_valid=0 for 1 cycle between rows 2 and 3, plus a 2-cycle enable=0 during DRAIN;
  - response: a zero diagonal is inserted; outputs and drain_cnt hold for those 2 cycles; done is delayed by exactly 2 cycles.
- Back-to-back batches with opposite sign:
  - stimulus: the second batch is offered continuously;
  - response: in_ready=0 for exactly MATRIX_WIDTH cycles after the last accept; no cycle has bytes from both batches on the diagonal.
- Reset mid-STREAM:
  - stimulus: rst=0 asynchronously after 2 rows;
  - response: systolic_data, systolic_signed, busy and done are 0 immediately; after reset release, in_ready=1 and no stale bytes appear.
- With SYSTOLIC_SETUP_ROW_COUNT_EN:
  - stimulus: a 4-row batch followed by a 1-row batch;
  - response: row_count reads 4 after the first batch, then 1 after the second.
